// File: rtl/syn_fifo_prog.sv
// Single-clock FIFO with selectable FWFT/registered read, programmable
// almost-full/almost-empty thresholds, occupancy count, sticky errors and flush.
module syn_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  wr_err;
  logic                  rd_err;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  // Flush masks both requests, so it neither moves data nor raises an error.
  assign rd_ok  = rd_en & ~empty & ~flush;
  assign wr_ok  = wr_en & (~full | rd_ok) & ~flush;
  assign wr_err = wr_en & ~wr_ok & ~flush;
  assign rd_err = rd_en & ~rd_ok & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; the reset branch only blocks a write while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | wr_err;
      underflow <= (underflow & ~clr_err) | rd_err;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown directly; zero while empty so reset/flush read as 0.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Directed bench for syn_fifo_prog: one FWFT instance and one registered-read
// instance, checked with immediate assertions against hand-computed values.
module tb_syn_fifo_prog;

  logic       clk;
  logic       rst_n;

  logic       flush, clr_err, wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic       rd_valid;
  logic [4:0] af_thresh, ae_thresh, count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  logic       r_flush, r_clr_err, r_wr_en, r_rd_en;
  logic [7:0] r_data_in, r_data_out;
  logic       r_rd_valid;
  logic [4:0] r_count;
  logic       r_full, r_empty, r_almost_full, r_almost_empty, r_overflow, r_underflow;

  int tests;
  int failures;

  syn_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  syn_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(r_flush), .clr_err(r_clr_err),
    .wr_en(r_wr_en), .data_in(r_data_in), .rd_en(r_rd_en),
    .data_out(r_data_out), .rd_valid(r_rd_valid),
    .af_thresh(5'd8), .ae_thresh(5'd2), .count(r_count),
    .full(r_full), .empty(r_empty), .almost_full(r_almost_full),
    .almost_empty(r_almost_empty), .overflow(r_overflow), .underflow(r_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of FWFT-instance requests, then returns inputs to idle.
  task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    tick();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  initial begin
    tests = 0;
    failures = 0;
    flush = 0; clr_err = 0; wr_en = 0; rd_en = 0; data_in = '0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    r_flush = 0; r_clr_err = 0; r_wr_en = 0; r_rd_en = 0; r_data_in = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_dout", data_out, 0);
    checkOutput("rst_valid", rd_valid, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_udf", underflow, 0);
    checkOutput("rst_r_valid", r_rd_valid, 0);
    rst_n = 1'b1;
    tick();

    // Fill with 0x00..0x0F, watching thresholds af=12 / ae=3.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("fill_count", count, i + 1);
      checkOutput("fill_af", almost_full, (i + 1 >= 12) ? 1 : 0);
      checkOutput("fill_ae", almost_empty, (i + 1 <= 3) ? 1 : 0);
      if (i == 11) begin
        af_thresh = 5'd13;
        #1;
        checkOutput("af_thresh13", almost_full, 0);
        af_thresh = 5'd12;
        #1;
      end
    end
    checkOutput("full_flag", full, 1);
    checkOutput("full_head", data_out, 8'h00);
    checkOutput("full_valid", rd_valid, 1);

    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_count", count, 16);
    checkOutput("ovf_head", data_out, 8'h00);
    checkOutput("ovf_udf", underflow, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("ovf_clr", overflow, 0);

    // Simultaneous read and write while full: head 0x00 leaves, 0x55 lands at slot 0.
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("rw_full_count", count, 16);
    checkOutput("rw_full_ovf", overflow, 0);
    for (int j = 1; j < 16; j++) begin
      checkOutput("drain_data", data_out, j);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("wrap_data", data_out, 8'h55);
    checkOutput("wrap_count", count, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_dout", data_out, 0);
    checkOutput("drain_valid", rd_valid, 0);
    checkOutput("drain_ovf", overflow, 0);
    checkOutput("drain_udf", underflow, 0);

    // Read and write together on empty: write lands, read is an underflow.
    applyStimulus(1'b1, 8'h33, 1'b1);
    checkOutput("empty_rw_udf", underflow, 1);
    checkOutput("empty_rw_count", count, 1);
    checkOutput("empty_rw_dout", data_out, 8'h33);
    checkOutput("empty_rw_valid", rd_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("empty_again", empty, 1);
    clr_err = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    clr_err = 1'b0;
    checkOutput("clr_vs_err", underflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("udf_clr", underflow, 0);

    // Flush beats a concurrent write and raises no error.
    applyStimulus(1'b1, 8'hC1, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b1, 8'hC3, 1'b0);
    flush = 1'b0;
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_dout", data_out, 0);
    checkOutput("flush_ovf", overflow, 0);

    // Registered-read instance.
    r_wr_en = 1'b1; r_data_in = 8'h11; tick();
    r_data_in = 8'h22; tick();
    r_wr_en = 1'b0;
    checkOutput("reg_count", r_count, 2);
    checkOutput("reg_idle_valid", r_rd_valid, 0);
    checkOutput("reg_idle_dout", r_data_out, 0);
    r_rd_en = 1'b1; tick();
    r_rd_en = 1'b0;
    checkOutput("reg_rd_dout", r_data_out, 8'h11);
    checkOutput("reg_rd_valid", r_rd_valid, 1);
    tick();
    checkOutput("reg_valid_pulse", r_rd_valid, 0);
    checkOutput("reg_dout_hold", r_data_out, 8'h11);
    r_flush = 1'b1; r_wr_en = 1'b1; r_data_in = 8'h77; tick();
    r_flush = 1'b0; r_wr_en = 1'b0;
    checkOutput("reg_flush_count", r_count, 0);
    checkOutput("reg_flush_empty", r_empty, 1);
    checkOutput("reg_flush_valid", r_rd_valid, 0);
    checkOutput("reg_flush_dout", r_data_out, 0);
    r_wr_en = 1'b1; r_data_in = 8'h99; tick();
    r_wr_en = 1'b0; r_rd_en = 1'b1; tick();
    r_rd_en = 1'b0;
    checkOutput("reg_post_flush", r_data_out, 8'h99);

    // Asynchronous reset in the middle of a write burst.
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    wr_en = 1'b1; data_in = 8'h03;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_empty", empty, 1);
    tick();
    wr_en = 1'b0;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_count", count, 0);
    checkOutput("post_rst_dout", data_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
